// File: rtl/dmem_pkg.sv
// Shared types and handshake encodings for the byte-masked data memory and
// the load/store unit that drives it.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam logic CS_ACTIVE = 1'b0;
  localparam logic WR_STORE  = 1'b0;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with per-byte write enables. A read
// updates rdata only on an enabled non-write cycle, so rdata holds otherwise.
module dmem_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] widx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [1<<AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[widx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle byte-masked data memory for the memory-writeback stage: accepts
// one request in IDLE, commits it after LATENCY edges and holds the result in DONE.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  input  logic        stall_in,
  output logic [31:0] data_rd,
  output logic        valid,
  output logic        err,
  output logic        mem_stall
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] req_widx_q, req_widx_d;
  logic          req_inr_q, req_inr_d;
  logic          req_wr_q, req_wr_d;
  logic [3:0]    req_mask_q, req_mask_d;
  logic [31:0]   req_data_q, req_data_d;
  logic          err_q, err_d;
  logic          rd_ok_q, rd_ok_d;

  logic          accept;
  logic          commit;
  logic          cur_inr;
  logic          cur_wr;
  logic [3:0]    cur_mask;
  logic [31:0]   cur_data;
  logic [AW-1:0] cur_widx;
  logic [31:0]   ram_rdata;
  logic          addr_unused;

  assign addr_unused = ^addr[1:0];

  // With LATENCY=1 the accept edge is also the commit edge, so the array is
  // fed straight from the inputs while in IDLE and from the captured request otherwise.
  always_comb begin
    accept   = (state_q == IDLE) && (cs == CS_ACTIVE);
    cur_inr  = (state_q == IDLE) ? (addr[31:AW+2] == '0) : req_inr_q;
    cur_widx = (state_q == IDLE) ? addr[AW+1:2] : req_widx_q;
    cur_wr   = (state_q == IDLE) ? wr : req_wr_q;
    cur_mask = (state_q == IDLE) ? mask : req_mask_q;
    cur_data = (state_q == IDLE) ? data_wr : req_data_q;
    commit   = (accept && (LATENCY == 1)) || ((state_q == BUSY) && (cnt_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_widx_q <= '0;
      req_inr_q  <= 1'b0;
      req_wr_q   <= 1'b0;
      req_mask_q <= '0;
      req_data_q <= '0;
      err_q      <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_widx_q <= req_widx_d;
      req_inr_q  <= req_inr_d;
      req_wr_q   <= req_wr_d;
      req_mask_q <= req_mask_d;
      req_data_q <= req_data_d;
      err_q      <= err_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_widx_d = req_widx_q;
    req_inr_d  = req_inr_q;
    req_wr_d   = req_wr_q;
    req_mask_d = req_mask_q;
    req_data_d = req_data_q;
    err_d      = err_q;
    rd_ok_d    = rd_ok_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_widx_d = addr[AW+1:2];
          req_inr_d  = (addr[31:AW+2] == '0);
          req_wr_d   = wr;
          req_mask_d = mask;
          req_data_d = data_wr;
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      DONE: begin
        if (!stall_in) begin
          state_d = IDLE;
          err_d   = 1'b0;
          rd_ok_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = !cur_inr;
      rd_ok_d = cur_inr && (cur_wr != WR_STORE);
    end
  end

  always_comb begin
    valid     = (state_q == DONE);
    mem_stall = accept || (state_q == BUSY);
    err       = valid && err_q;
    data_rd   = (valid && rd_ok_q) ? ram_rdata : 32'd0;
  end

  // Reset wins over a commit landing on the same edge, so an aborted store never lands.
  dmem_array #(
    .AW (AW)
  ) u_array (
    .clk   (clk),
    .en    (commit && cur_inr && !rst),
    .we    (cur_wr == WR_STORE),
    .be    (cur_mask),
    .widx  (cur_widx),
    .wdata (cur_data),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl against a word-array reference model,
// plus directed handshake, stall, out-of-range and reset-abort scenarios.
module tb_data_mem_ctrl;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic        stall_in;
  logic [31:0] data_rd;
  logic        valid;
  logic        err;
  logic        mem_stall;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];

  data_mem_ctrl #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .wr        (wr),
    .mask      (mask),
    .addr      (addr),
    .data_wr   (data_wr),
    .stall_in  (stall_in),
    .data_rd   (data_rd),
    .valid     (valid),
    .err       (err),
    .mem_stall (mem_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Called at a falling edge with the DUT in IDLE; returns at the falling edge
  // of the IDLE cycle that follows the access, with cs released.
  task automatic access(input logic w, input logic [3:0] m, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
    logic [31:0] exp_d;
    logic        exp_e;
    int          word;
    int          cyc;
    int          stalls;
    logic        got;
    word = int'(a >> 2);
    if (a >= 32'(4 * DEPTH)) begin
      exp_d = 32'd0;
      exp_e = 1'b1;
    end else if (w == 1'b0) begin
      for (int i = 0; i < 4; i++)
        if (m[i]) ref_mem[word][8*i +: 8] = d[8*i +: 8];
      exp_d = 32'd0;
      exp_e = 1'b0;
    end else begin
      exp_d = ref_mem[word];
      exp_e = 1'b0;
    end
    exp_q.push_back(exp_d);

    cs = 1'b0; wr = w; mask = m; addr = a; data_wr = d;
    stall_in = 1'($urandom_range(0, 1));
    #1;
    check("stall_accept", 32'(mem_stall), 32'd1);
    @(posedge clk);
    #1;
    wr = 1'($urandom_range(0, 1));
    mask = 4'($urandom_range(0, 15));
    addr = $urandom;
    data_wr = $urandom;
    cyc = 0; stalls = 1; got = 1'b0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      cyc++;
      if (valid) got = 1'b1;
      else if (mem_stall) stalls++;
    end
    exp_d = exp_q.pop_front();
    check("valid_seen", 32'(got), 32'd1);
    if (!got) begin
      cs = 1'b1;
      stall_in = 1'b0;
      return;
    end
    check("latency", 32'(cyc), 32'(LAT));
    check("stall_cycles", 32'(stalls), 32'(LAT));
    check("err", 32'(err), 32'(exp_e));
    check("data_rd", data_rd, exp_d);
    check("stall_done", 32'(mem_stall), 32'd0);
    stall_in = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_data", data_rd, exp_d);
      check("hold_err", 32'(err), 32'(exp_e));
      check("hold_stall", 32'(mem_stall), 32'd0);
    end
    stall_in = 1'b0;
    @(negedge clk);
    check("idle_valid", 32'(valid), 32'd0);
    check("idle_data", data_rd, 32'd0);
    check("idle_err", 32'(err), 32'd0);
    check("idle_stall", 32'(mem_stall), 32'd1);
    cs = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; cs = 1'b1; wr = 1'b1; mask = '0; addr = '0; data_wr = '0; stall_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", data_rd, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("quiet_valid", 32'(valid), 32'd0);
      check("quiet_stall", 32'(mem_stall), 32'd0);
      check("quiet_data", data_rd, 32'd0);
    end

    for (int i = 0; i < 16; i++) access(1'b0, 4'hF, 32'(i * 4), $urandom, 0);

    access(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 0);
    access(1'b1, 4'h0, 32'h10, 32'h0, 0);
    access(1'b0, 4'b0100, 32'h10, 32'h00AA0000, 0);
    access(1'b1, 4'h0, 32'h13, 32'h0, 0);
    check("byte_merge_ref", ref_mem[4], 32'hDEAABEEF);
    access(1'b1, 4'h0, 32'h10, 32'h0, 3);
    access(1'b0, 4'hF, 32'(4 * DEPTH), 32'hCAFEF00D, 0);
    access(1'b1, 4'h0, 32'(4 * DEPTH + 8), 32'h0, 1);
    access(1'b1, 4'h0, 32'h0, 32'h0, 0);

    access(1'b0, 4'hF, 32'h20, 32'h12345678, 0);
    cs = 1'b0; wr = 1'b0; mask = 4'hF; addr = 32'h20; data_wr = 32'hFFFFFFFF;
    @(negedge clk);
    check("abort_busy", 32'(mem_stall), 32'd1);
    rst = 1'b1; cs = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_stall", 32'(mem_stall), 32'd0);
    check("abort_data", data_rd, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_quiet", 32'(valid), 32'd0);
    end
    access(1'b1, 4'h0, 32'h20, 32'h0, 0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 1000));
        else a = $urandom | 32'h8000_0000;
      end else begin
        a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      end
      access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
             $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          check("gap_stall", 32'(mem_stall), 32'd0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
